// File: rtl/instr_encoder_loader.sv
// Encodes decoded operation requests into 32-bit MIPS words and streams them into instruction memory.
// Optional NOP padding after the last word is enabled by defining INSTR_ENCODER_NOP_PAD_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

`ifdef INSTR_ENCODER_NOP_PAD_EN
  typedef enum logic [2:0] {IDLE, LOAD, PAD, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DONE, ERR} state_t;
`endif

  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  state_t              stateReg, stateNext;
  logic [ADDR_W-1:0]   ptrReg, ptrNext;
  logic [ADDR_W:0]     countReg, countNext;
  logic                errReg, errNext;
  logic                fullReg, fullNext;
  logic                weReg, weNext;
  logic [ADDR_W-1:0]   addrReg, addrNext;
  logic [31:0]         dataReg, dataNext;
  logic                accept;

  function automatic logic [31:0] encodeInstr(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    logic [5:0] funct;
    logic [5:0] opcode;
    logic       isRType;
    funct   = 6'b000000;
    opcode  = 6'b000000;
    isRType = 1'b1;
    case (op)
      4'd0:    funct = 6'b100000;
      4'd1:    funct = 6'b100010;
      4'd2:    funct = 6'b100100;
      4'd3:    funct = 6'b100101;
      4'd4:    funct = 6'b100110;
      4'd5:    funct = 6'b101010;
      4'd6:    funct = 6'b101001;
      4'd7:    begin isRType = 1'b0; opcode = 6'b100011; end
      4'd8:    begin isRType = 1'b0; opcode = 6'b101011; end
      4'd9:    begin isRType = 1'b0; opcode = 6'b001000; end
      4'd10:   begin isRType = 1'b0; opcode = 6'b001100; end
      4'd11:   begin isRType = 1'b0; opcode = 6'b001101; end
      4'd12:   begin isRType = 1'b0; opcode = 6'b001110; end
      4'd13:   begin isRType = 1'b0; opcode = 6'b001010; end
      4'd14:   begin isRType = 1'b0; opcode = 6'b001001; end
      default: ;
    endcase
    return isRType ? {6'b000000, rs, rt, rd, 5'b00000, funct} : {opcode, rs, rt, imm};
  endfunction

  assign req_ready  = (stateReg == LOAD) && !fullReg;
  assign accept     = req_valid && req_ready;
  assign imem_we    = weReg;
  assign imem_addr  = addrReg;
  assign imem_wdata = dataReg;
  assign err        = errReg;
  assign count      = countReg;
  assign done       = (stateReg == DONE);
`ifdef INSTR_ENCODER_NOP_PAD_EN
  assign busy       = (stateReg == LOAD) || (stateReg == PAD) || (stateReg == DONE);
`else
  assign busy       = (stateReg == LOAD) || (stateReg == DONE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      ptrReg   <= '0;
      countReg <= '0;
      errReg   <= 1'b0;
      fullReg  <= 1'b0;
      weReg    <= 1'b0;
      addrReg  <= '0;
      dataReg  <= '0;
    end else begin
      stateReg <= stateNext;
      ptrReg   <= ptrNext;
      countReg <= countNext;
      errReg   <= errNext;
      fullReg  <= fullNext;
      weReg    <= weNext;
      addrReg  <= addrNext;
      dataReg  <= dataNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    ptrNext   = ptrReg;
    countNext = countReg;
    errNext   = errReg;
    fullNext  = fullReg;
    weNext    = 1'b0;
    addrNext  = addrReg;
    dataNext  = dataReg;
    case (stateReg)
      LOAD: begin
        // The top word was written last cycle and the session did not end: no wrap-around.
        if (fullReg) begin
          stateNext = ERR;
          errNext   = 1'b1;
        end else if (accept) begin
          if (req_op == OP_ILLEGAL) begin
            stateNext = ERR;
            errNext   = 1'b1;
          end else begin
            weNext    = 1'b1;
            addrNext  = ptrReg;
            dataNext  = encodeInstr(req_op, req_rs, req_rt, req_rd, req_imm);
            ptrNext   = ptrReg + ADDR_W'(1);
            countNext = countReg + (ADDR_W+1)'(1);
            if (&ptrReg) fullNext = 1'b1;
            if (req_last) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
              stateNext = PAD;
`else
              stateNext = DONE;
`endif
            end
          end
        end
      end
`ifdef INSTR_ENCODER_NOP_PAD_EN
      PAD: begin
        if (fullReg) begin
          stateNext = ERR;
          errNext   = 1'b1;
        end else begin
          weNext    = 1'b1;
          addrNext  = ptrReg;
          dataNext  = 32'h0000_0000;
          ptrNext   = ptrReg + ADDR_W'(1);
          countNext = countReg + (ADDR_W+1)'(1);
          stateNext = DONE;
        end
      end
`endif
      IDLE, DONE, ERR: begin
        if (stateReg == DONE) stateNext = IDLE;
        if (start) begin
          ptrNext   = base_addr;
          countNext = '0;
          errNext   = 1'b0;
          fullNext  = 1'b0;
          stateNext = LOAD;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against a table-driven encoding model.
// Expectations follow INSTR_ENCODER_NOP_PAD_EN when it is defined.
module tb_instr_encoder_loader;
  localparam int AW = 8;
  localparam int TOP = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = '0;
  logic [4:0]    req_rs = '0;
  logic [4:0]    req_rt = '0;
  logic [4:0]    req_rd = '0;
  logic [15:0]   req_imm = '0;
  logic          req_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    bit          last;
    bit          hasLit;
    logic [31:0] lit;
  } req_t;

  req_t reqQ[$];
  int numChecks = 0;
  int numFails = 0;
  int expWrites = 0;
  int seenWrites = 0;
  int unsigned functTab[7] = '{32, 34, 36, 37, 38, 42, 41};
  int unsigned opcTab[8] = '{35, 43, 8, 12, 13, 14, 10, 9};

  always @(negedge clk) if (rst_n && imem_we) seenWrites++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refEncode(input req_t r);
    int unsigned rs = r.rs;
    int unsigned rt = r.rt;
    int unsigned rd = r.rd;
    int unsigned imm = r.imm;
    int unsigned w;
    if (r.op < 7) w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + functTab[r.op];
    else          w = opcTab[r.op - 7] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    return w;
  endfunction

  function automatic req_t mkReq(input int op, input int rs, input int rt, input int rd,
                                 input int imm, input bit last, input bit hasLit, input logic [31:0] lit);
    req_t r;
    r.op = 4'(op); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.imm = 16'(imm);
    r.last = last; r.hasLit = hasLit; r.lit = lit;
    return r;
  endfunction

  task automatic driveReq(input req_t r);
    req_valid = 1'b1;
    req_op = r.op; req_rs = r.rs; req_rt = r.rt; req_rd = r.rd; req_imm = r.imm; req_last = r.last;
  endtask

  // Plays reqQ as one session from base; the model tracks pointer, count and full by plain arithmetic.
  task automatic runSession(input int base, input bit gaps);
    int  ptr = base;
    int  cnt = 0;
    bit  full = 0;
    bit  ended = 0;
    bit  failed = 0;
    start = 1'b1; base_addr = AW'(base);
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_count", count, 0);
    check("start_err", err, 0);
    check("start_we", imem_we, 0);
    foreach (reqQ[i]) begin
      if (ended) break;
      if (gaps) begin
        int ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) begin
          req_valid = 1'b0; req_op = 4'($urandom); req_last = 1'($urandom);
          if (!full && $urandom_range(0, 3) == 0) begin start = 1'b1; base_addr = AW'($urandom); end
          @(negedge clk);
          start = 1'b0;
          check("gap_we", imem_we, 0);
          check("gap_count", count, cnt);
        end
      end
      driveReq(reqQ[i]);
      check("ready", req_ready, !full);
      @(negedge clk);
      req_valid = 1'b0;
      if (full || reqQ[i].op == 4'd15) begin
        check("stop_we", imem_we, 0);
        check("stop_err", err, 1);
        check("stop_ready", req_ready, 0);
        check("stop_count", count, cnt);
        ended = 1; failed = 1;
      end else begin
        check("wr_we", imem_we, 1);
        check("wr_addr", imem_addr, ptr);
        check("wr_data", imem_wdata, refEncode(reqQ[i]));
        if (reqQ[i].hasLit) check("wr_literal", imem_wdata, reqQ[i].lit);
        cnt++; expWrites++;
        check("wr_count", count, cnt);
        if (ptr == TOP) full = 1;
        ptr = (ptr + 1) % (TOP + 1);
        if (reqQ[i].last) begin
          ended = 1;
`ifdef INSTR_ENCODER_NOP_PAD_EN
          check("pad_nodone", done, 0);
          check("pad_busy", busy, 1);
          @(negedge clk);
          if (full) begin
            check("pad_full_we", imem_we, 0);
            check("pad_full_err", err, 1);
            failed = 1;
          end else begin
            check("nop_we", imem_we, 1);
            check("nop_addr", imem_addr, ptr);
            check("nop_data", imem_wdata, 0);
            cnt++; expWrites++;
            check("nop_count", count, cnt);
            check("nop_done", done, 1);
          end
`else
          check("last_done", done, 1);
          check("last_busy", busy, 1);
`endif
          if (!failed) begin
            @(negedge clk);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_we", imem_we, 0);
            check("idle_count", count, cnt);
          end
        end else if (full) begin
          check("full_drop", req_ready, 0);
        end
      end
    end
    if (!ended && full) begin
      @(negedge clk);
      failed = 1;
    end
    if (failed) begin
      @(negedge clk);
      check("err_hold", err, 1);
      check("err_we", imem_we, 0);
      check("err_busy", busy, 0);
      check("err_ready", req_ready, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    reqQ = {};
    reqQ.push_back(mkReq(0, 1, 2, 3, 16'hABCD, 1, 1, 32'h0022_1820));
    runSession(32'h10, 0);

    reqQ = {};
    reqQ.push_back(mkReq(7, 29, 8, 0, 16'h0004, 0, 1, 32'h8FA8_0004));
    reqQ.push_back(mkReq(6, 5, 6, 4, 16'h0000, 0, 1, 32'h00A6_2029));
    reqQ.push_back(mkReq(9, 0, 1, 0, 16'hFFFF, 1, 1, 32'h2001_FFFF));
    runSession(0, 0);

    reqQ = {};
    reqQ.push_back(mkReq(1, 3, 4, 5, 0, 0, 0, 0));
    reqQ.push_back(mkReq(15, 3, 4, 5, 0, 0, 0, 0));
    reqQ.push_back(mkReq(2, 3, 4, 5, 0, 1, 0, 0));
    runSession(32'h40, 0);

    reqQ = {};
    reqQ.push_back(mkReq(10, 1, 2, 3, 16'h1111, 0, 0, 0));
    reqQ.push_back(mkReq(11, 4, 5, 6, 16'h2222, 0, 0, 0));
    reqQ.push_back(mkReq(12, 7, 8, 9, 16'h3333, 0, 0, 0));
    runSession(32'hFE, 0);

    reqQ = {};
    reqQ.push_back(mkReq(11, 2, 2, 0, 16'h00FF, 1, 1, 32'h3442_00FF));
    runSession(0, 0);

    reqQ = {};
    reqQ.push_back(mkReq(8, 31, 31, 31, 16'h8000, 1, 0, 0));
    runSession(TOP, 0);

    for (int s = 0; s < 25; s++) begin
      int len = $urandom_range(1, 6);
      int base = ($urandom_range(0, 1) == 1) ? $urandom_range(0, TOP) : $urandom_range(TOP - 5, TOP);
      reqQ = {};
      for (int k = 0; k < len; k++) begin
        int op = ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 14);
        reqQ.push_back(mkReq(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                             $urandom_range(0, 65535), k == len - 1, 0, 0));
      end
      runSession(base, 1);
    end

    // Asynchronous reset while the accepted word's write is on the bus.
    start = 1'b1; base_addr = 8'h20;
    @(negedge clk);
    start = 1'b0;
    driveReq(mkReq(4, 9, 10, 11, 0, 0, 0, 0));
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    check("pre_rst_we", imem_we, 1);
    rst_n = 1'b0;
    #1;
    check("arst_we", imem_we, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_wdata", imem_wdata, 0);
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_we", imem_we, 0);

    reqQ = {};
    reqQ.push_back(mkReq(5, 1, 2, 3, 0, 1, 0, 0));
    runSession(32'h80, 1);

    repeat (2) @(negedge clk);
    check("total_writes", seenWrites, expWrites);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end
endmodule
